// File: rtl/vit_pkg.sv
// Shared definitions for the Viterbi compare-select stage: metric field
// layout and the sequencer state encoding.
package vit_pkg;

  // IEEE-754 single-precision field boundaries; bit 31 (sign) is never compared.
  localparam int METRIC_W = 32;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } acs_state_e;

endpackage

// File: rtl/acs_select_sched_if.sv
// Bus bundle between the compare-select sequencer and its environment:
// control handshake, candidate RAM read port, survivor write port and
// best-state result.
interface acs_select_sched_if
  import vit_pkg::*;
#(
  parameter int NUM_STATES = 8,
  parameter int W          = METRIC_W,
  parameter int ADDR_W     = $clog2(NUM_STATES)
);

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]      rd_cand0;
  logic [W-1:0]      rd_cand1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_metric;
  logic              wr_surv;
  logic [ADDR_W-1:0] best_state;
  logic [W-1:0]      best_metric;

  // Environment side: issues start/abort and returns candidate metrics.
  modport master (
    output start, abort, rd_cand0, rd_cand1,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_metric, wr_surv,
           best_state, best_metric
  );

  // Sequencer side.
  modport slave (
    input  start, abort, rd_cand0, rd_cand1,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_metric, wr_surv,
           best_state, best_metric
  );

endinterface

// File: rtl/fp_pos_gt.sv
// Positive-float magnitude comparator: b_gt_a is 1 when |b| > |a|.
// For IEEE-754 values the exponent/mantissa bits order the same way as an
// unsigned integer, so a single 31-bit compare suffices. Equal gives 0.
module fp_pos_gt
  import vit_pkg::*;
(
  input  logic [METRIC_W-1:0] a,
  input  logic [METRIC_W-1:0] b,
  output logic                b_gt_a
);

  logic [EXP_MSB:0] mag_a;
  logic [EXP_MSB:0] mag_b;
  logic             unused_sign_bits;

  assign mag_a  = {a[EXP_MSB:EXP_LSB], a[MAN_MSB:0]};
  assign mag_b  = {b[EXP_MSB:EXP_LSB], b[MAN_MSB:0]};
  assign b_gt_a = (mag_b > mag_a);

  // Sign bits are deliberately ignored.
  assign unused_sign_bits = a[METRIC_W-1] ^ b[METRIC_W-1];

endmodule

// File: rtl/acs_select_sched.sv
// Compare-select sequencer for one Viterbi trellis step. Reads both
// candidate metrics of every state, keeps the larger one, writes survivor
// metric plus decision bit, and tracks the best state of the step.
// Pipeline: read strobe -> data valid -> registered write (two cycles).
module acs_select_sched
  import vit_pkg::*;
#(
  parameter int NUM_STATES = 8,
  parameter int W          = METRIC_W,
  parameter int ADDR_W     = $clog2(NUM_STATES)
) (
  input logic              clk,
  input logic              rst_n,
  acs_select_sched_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_STATES - 1);

  acs_state_e        state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] vaddr_q;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [W-1:0]      wr_metric_q;
  logic              wr_surv_q;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] best_state_q;
  logic [W-1:0]      best_metric_q;

  logic              kill;
  logic              cand1_wins;
  logic [W-1:0]      winner;
  logic              winner_beats_best;
  logic              best_load;

  // Candidate select: ties favour cand0.
  fp_pos_gt u_sel_cmp (
    .a      (bus.rd_cand0),
    .b      (bus.rd_cand1),
    .b_gt_a (cand1_wins)
  );

  assign winner = cand1_wins ? bus.rd_cand1 : bus.rd_cand0;

  // Best-state update: strictly greater only, so ties keep the lower index.
  fp_pos_gt u_best_cmp (
    .a      (best_metric_q),
    .b      (winner),
    .b_gt_a (winner_beats_best)
  );

  assign kill      = bus.abort && (state_q != IDLE);
  assign best_load = wr_en_d && ((vaddr_q == '0) || winner_beats_best);

  // Next-state, read-issue and pipeline-control logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (bus.abort || done_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = rd_en_q && !kill;
    wr_en_d = valid_q && !kill;
    done_d  = wr_en_d && (vaddr_q == LAST_ADDR) && (state_q == DRAIN);
    busy_d  = (state_d != IDLE);
  end

  // Control registers: FSM, read port and one-stage valid/address pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      valid_q   <= 1'b0;
      vaddr_q   <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      valid_q   <= valid_d;
      if (rd_en_q) begin
        vaddr_q <= rd_addr_q;
      end
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Survivor write port and best-state tracking; both hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q     <= '0;
      wr_metric_q   <= '0;
      wr_surv_q     <= 1'b0;
      best_state_q  <= '0;
      best_metric_q <= '0;
    end else begin
      if (wr_en_d) begin
        wr_addr_q   <= vaddr_q;
        wr_metric_q <= winner;
        wr_surv_q   <= cand1_wins;
      end
      if (best_load) begin
        best_state_q  <= vaddr_q;
        best_metric_q <= winner;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_metric   = wr_metric_q;
  assign bus.wr_surv     = wr_surv_q;
  assign bus.best_state  = best_state_q;
  assign bus.best_metric = best_metric_q;

endmodule
